ldm_stm_sequencer: RTL
======================

Name: ldm_stm_sequencer

Overview:
Multicycle sequencer for ARM block transfers (LDM/STM). On a start pulse it walks the 16-bit register list from r0 to r15. It drives the register-file read number (STM) or write port (LDM), and issues one word memory access per listed register over a req/ready handshake. It then optionally writes the updated base back through the same single register-file write port.

Parameters:
ADDR_W, 32, width of the address and data paths
NREG, 16, number of architectural registers (register-list width; register number width is 4)

Ports:
clk  in  1  system clock, all state updates on posedge
reset  in  1  synchronous, active-low reset
start  in  1  begin a transfer; sampled only in IDLE
load  in  1  1 = LDM, 0 = STM; latched at start
reglist  in  16  register list; latched at start
pu  in  2  {P,U}: 00 DA, 01 IA, 10 DB, 11 IB; latched at start
wb  in  1  base writeback enable; latched at start
basenum  in  4  base register number; latched at start
base  in  32  base register value; latched at start
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  32  word address of the current transfer
mem_wdata  out  32  store data, equal to rf_rdata
mem_rdata  in  32  load data, valid when mem_ready = 1
mem_ready  in  1  memory accepts/completes the current request this cycle
rf_num  out  4  register-file read number (current register)
rf_rdata  in  32  register-file asynchronous read data for rf_num
rf_write  out  1  register-file write enable
rf_writenum  out  4  register-file write number
rf_wdata  out  32  register-file write data
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, WB, DONE. busy = 1 in XFER, WB and DONE.
- Reset (reset = 0 at posedge):
  - State goes to IDLE and any in-flight operation is abandoned.
  - All registered outputs and latched fields clear to 0.
  - mem_req, rf_write, busy and done are 0 from the next cycle.
- IDLE, start = 1: latch all inputs and compute cnt = popcount(reglist).
  - cnt = 0: go to DONE; no memory or register-file activity.
  - cnt > 0: go to XFER with cur = lowest set bit.
- Start address (mod 2^32), lowest register always at the lowest address:
  - IA: base
  - IB: base + 4
  - DA: base - 4*cnt + 4
  - DB: base - 4*cnt
- Final base: U = 1 gives base + 4*cnt; U = 0 gives base - 4*cnt.
- XFER outputs:
  - mem_req = 1, mem_we = ~load, mem_addr = current address, rf_num = cur.
  - mem_wdata = rf_rdata (combinational).
- XFER handshake:
  - mem_addr, mem_we and rf_num stay stable while mem_ready = 0. Unbounded wait states are allowed.
  - Accept = mem_req & mem_ready. On accept: address += 4, cur = next set bit above cur.
- LDM write: in the accept cycle, rf_write = 1, rf_writenum = cur, rf_wdata = mem_rdata (combinational from inputs). The regfile captures it at the same posedge.
- After the last accept:
  - Go to WB if wb = 1 and not (load = 1 and reglist[basenum] = 1).
  - Otherwise go to DONE.
  - An LDM with the base in the list keeps the loaded value; base writeback is suppressed.
  - An STM with the base in the list stores the original base value.
- WB: rf_write = 1, rf_writenum = basenum, rf_wdata = final base, mem_req = 0. Then go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. A new start is accepted in the IDLE cycle that follows.
- start is ignored in XFER, WB and DONE.
- r15 is treated as an ordinary register: the loaded value is written to regfile entry 15 and no PC side effects are generated here.
- Minimum latency with mem_ready tied high:
  - start sampled at edge 0; transfers occupy cycles 1..cnt.
  - WB (if taken) in cycle cnt+1; DONE in the next cycle.
- At most one rf_write per cycle by construction: load writes only occur in XFER, base writes only in WB.

Test Plan:
1. Hold reset = 0 for 2 cycles with start = 1 -> mem_req, rf_write, busy and done stay 0. After reset = 1 and start = 0, the block remains in IDLE.
2. STM IA: base = 0x1000, reglist = 0x0016, wb = 1, basenum = 13, mem_ready = 1 ->
   - cycles 1-3: mem_addr 0x1000/0x1004/0x1008, rf_num 1/2/4, mem_we = 1, mem_wdata tracks rf_rdata.
   - cycle 4: rf_write r13 = 0x100C.
   - cycle 5: done.
3. LDM DB: base = 0x2000, reglist = 0x8003, wb = 1, basenum = 13, mem_ready low for 2 cycles before each accept ->
   - addresses 0x1FF4/0x1FF8/0x1FFC, each held through the wait states.
   - rf_write r0/r1/r15 only in accept cycles, with mem_rdata.
   - then r13 = 0x1FF4, then done.
4. LDM IB: basenum = 3, base = 0x3000, reglist = 0x0009, wb = 1 -> addresses 0x3004 (r0) and 0x3008 (r3). r3 receives the loaded data; no WB cycle; done immediately after the second accept.
5. Empty list: start with reglist = 0 -> next cycle done = 1 and busy = 1; mem_req and rf_write are never asserted. A second start during DONE is ignored.
6. STM of 4 registers with reset = 0 after the first accept -> next cycle mem_req = 0, busy = 0, no WB. A fresh start afterwards begins at the newly computed start address.

Source files
------------

// File: rtl/ldm_stm_sequencer.sv
// Multicycle LDM/STM block-transfer sequencer: walks the register list from r0
// upward, issues one word access per listed register, then optionally writes back the base.
module ldm_stm_sequencer #(
    parameter int ADDR_W = 32,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    load,
    input  logic [NREG-1:0]         reglist,
    input  logic [1:0]              pu,
    input  logic                    wb,
    input  logic [$clog2(NREG)-1:0] basenum,
    input  logic [ADDR_W-1:0]       base,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ADDR_W-1:0]       mem_wdata,
    input  logic [ADDR_W-1:0]       mem_rdata,
    input  logic                    mem_ready,
    output logic [$clog2(NREG)-1:0] rf_num,
    input  logic [ADDR_W-1:0]       rf_rdata,
    output logic                    rf_write,
    output logic [$clog2(NREG)-1:0] rf_writenum,
    output logic [ADDR_W-1:0]       rf_wdata,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(NREG);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic              load_r;
    logic              wb_go_r;
    logic [RW-1:0]     basenum_r;
    logic [NREG-1:0]   pend_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] final_r;

    logic [RW:0]       cnt;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] final_base;
    logic [RW-1:0]     cur;
    logic [NREG-1:0]   pend_next;
    logic              accept;

    function automatic logic [RW:0] popcount(input logic [NREG-1:0] v);
        popcount = '0;
        for (int i = 0; i < NREG; i++)
            popcount = popcount + (RW+1)'(v[i]);
    endfunction

    function automatic logic [RW-1:0] lowest_set(input logic [NREG-1:0] v);
        lowest_set = '0;
        for (int i = NREG - 1; i >= 0; i--)
            if (v[i]) lowest_set = RW'(i);
    endfunction

    // Lowest register always sits at the lowest address, so every mode walks upward.
    always_comb begin
        cnt        = popcount(reglist);
        span       = ADDR_W'({cnt, 2'b00});
        final_base = pu[0] ? base + span : base - span;
        case (pu)
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + ADDR_W'(4);
            2'b00:   start_addr = base - span + ADDR_W'(4);
            default: start_addr = base - span;
        endcase
    end

    assign cur       = lowest_set(pend_r);
    assign pend_next = pend_r & ~(NREG'(1) << cur);
    assign accept    = (state == S_XFER) && mem_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            load_r    <= 1'b0;
            wb_go_r   <= 1'b0;
            basenum_r <= '0;
            pend_r    <= '0;
            addr_r    <= '0;
            final_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        load_r    <= load;
                        basenum_r <= basenum;
                        pend_r    <= reglist;
                        addr_r    <= start_addr;
                        final_r   <= final_base;
                        // NOTE: an LDM that loads its own base keeps the loaded value, so writeback is dropped.
                        wb_go_r   <= wb && !(load && reglist[basenum]);
                        state     <= (cnt == '0) ? S_DONE : S_XFER;
                    end
                end
                S_XFER: begin
                    if (accept) begin
                        pend_r <= pend_next;
                        addr_r <= addr_r + ADDR_W'(4);
                        if (pend_next == '0)
                            state <= wb_go_r ? S_WB : S_DONE;
                    end
                end
                S_WB:    state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mem_req     = (state == S_XFER);
    assign mem_we      = mem_req && !load_r;
    assign mem_addr    = addr_r;
    assign mem_wdata   = rf_rdata;
    assign rf_num      = cur;
    assign rf_write    = (accept && load_r) || (state == S_WB);
    assign rf_writenum = (state == S_WB) ? basenum_r : cur;
    assign rf_wdata    = (state == S_WB) ? final_r : mem_rdata;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule
